// File: rtl/shift_serial_ctrl.sv
// Shares one external right-shift register between two requesters and streams each word LSB-first.
// Define ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_serial_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_data_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_data_i,
    output logic             req1_ready_o,
    output logic             sr_load_o,
    output logic             sr_shift_o,
    output logic [WIDTH-1:0] sr_data_o,
    input  logic [WIDTH-1:0] sr_q_i,
    output logic             ser_bit_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             grant_id_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             grant_q, grant_d;
    logic             pick1;
    logic             accept;

`ifdef ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        pick1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
    end
`else
    always_comb begin
        pick1 = req1_valid_i && !req0_valid_i;
    end
`endif

    assign accept       = !rst_i && (state_q == IDLE) && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && !pick1;
    assign req1_ready_o = accept && pick1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        grant_d = grant_q;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d  = pick1 ? req1_data_i : req0_data_i;
                    grant_d = pick1;
`ifdef ARB_RR_EN
                    last_grant_d = pick1;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            grant_q <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            grant_q <= grant_d;
`ifdef ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // ser_bit reads the register's LSB before this cycle's shift takes effect.
    assign sr_load_o   = (state_q == LOAD);
    assign sr_shift_o  = (state_q == SHIFT);
    assign sr_data_o   = word_q;
    assign ser_valid_o = (state_q == SHIFT);
    assign ser_bit_o   = (state_q == SHIFT) && sr_q_i[0];
    assign ser_last_o  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign grant_id_o  = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_shift_serial_ctrl.sv
// Bench for shift_serial_ctrl: timeline model per word, a shift-register model, and directed scenarios.
// Expected arbitration follows ARB_RR_EN when it is defined for the build.
module tb_shift_serial_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         r0, r1, srLoad, srShift, serBit, serValid, serLast, grantId, busy, done;
    logic [W-1:0] srData, srQ;

    always #5 clk = ~clk;

    shift_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
        .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
        .sr_load_o(srLoad), .sr_shift_o(srShift), .sr_data_o(srData), .sr_q_i(srQ),
        .ser_bit_o(serBit), .ser_valid_o(serValid), .ser_last_o(serLast),
        .grant_id_o(grantId), .busy_o(busy), .done_o(done)
    );

    // External right-shift register the controller drives.
    always @(posedge clk) begin
        if (rst)          srQ <= '0;
        else if (srLoad)  srQ <= srData;
        else if (srShift) srQ <= srQ >> 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s got=timeout exp=ready (cycle %0d)", name, cyc);
    endtask

    function automatic logic modelPick1(input logic a, input logic b, input logic last);
`ifdef ARB_RR_EN
        return b && (!a || !last);
`else
        return b && !a;
`endif
    endfunction

    // Model: mPhase counts cycles since accept (0 idle, 1 load, 2..W+1 bits, W+2 done).
    int           mPhase = 0;
    logic [W-1:0] mWord = '0;
    logic         mGrant = 1'b0;
    logic         mLast = 1'b1;
    bit           chkOn = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mPhase = 0; mWord = '0; mGrant = 1'b0; mLast = 1'b1;
        end else if (mPhase == 0) begin
            if (v0 || v1) begin
                mGrant = modelPick1(v0, v1, mLast);
                mLast  = mGrant;
                mWord  = mGrant ? d1 : d0;
                mPhase = 1;
            end
        end else if (mPhase == W + 2) begin
            mPhase = 0;
        end else begin
            mPhase++;
        end
    end

    always @(negedge clk) begin
        logic anyReq, p1, shifting, expBit;
        if (chkOn) begin
            anyReq   = !rst && (mPhase == 0) && (v0 || v1);
            p1       = modelPick1(v0, v1, mLast);
            shifting = (mPhase >= 2) && (mPhase <= W + 1);
            expBit   = shifting ? mWord[mPhase-2] : 1'b0;
            checkOutput("req0_ready", r0, anyReq && !p1);
            checkOutput("req1_ready", r1, anyReq && p1);
            checkOutput("sr_load", srLoad, mPhase == 1);
            checkOutput("sr_shift", srShift, shifting);
            checkOutput("ser_valid", serValid, shifting);
            checkOutput("ser_bit", serBit, expBit);
            checkOutput("ser_last", serLast, mPhase == W + 1);
            checkOutput("done", done, mPhase == W + 2);
            checkOutput("busy", busy, mPhase != 0);
            checkOutput("sr_data", srData, mWord);
            checkOutput("grant_id", grantId, mGrant);
        end
    end

    // Observed traffic, used for the literal expectations below.
    int           readyCnt0 = 0, readyCnt1 = 0, doneCnt = 0;
    int           acceptTimes[$];
    logic [W-1:0] wordsOut[$];
    logic         grantsOut[$];
    logic [W-1:0] capWord = '0;

    always @(negedge clk) begin
        if (chkOn) begin
            if (r0) readyCnt0++;
            if (r1) readyCnt1++;
            if (r0 || r1) acceptTimes.push_back(cyc);
            if (done) doneCnt++;
            if (serValid) begin
                capWord = {serBit, capWord[W-1:1]};
                if (serLast) begin
                    wordsOut.push_back(capWord);
                    grantsOut.push_back(grantId);
                end
            end
        end
    end

    task automatic applyStimulus(input bit id, input logic valid, input logic [W-1:0] data);
        if (id) begin v1 = valid; d1 = data; end
        else    begin v0 = valid; d0 = data; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Returns one time unit after the edge on which the handshake completed.
    task automatic waitReady(input int which);
        int n = 0;
        forever begin
            @(negedge clk);
            if ((which == 0 && r0 === 1'b1) || (which == 1 && r1 === 1'b1) ||
                (which == 2 && (r0 === 1'b1 || r1 === 1'b1))) break;
            n++;
            if (n > 60) begin timeoutFail("wait_ready"); return; end
        end
        @(posedge clk); #1;
    endtask

    task automatic sendWord(input bit id, input logic [W-1:0] data);
        applyStimulus(id, 1'b1, data);
        waitReady(id ? 1 : 0);
        applyStimulus(id, 1'b0, data);
    endtask

    initial begin
        int nW, nD, nA;
        @(posedge clk); #1;
        chkOn = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_sr_data", srData, 4'h0);
        checkOutput("rst_grant", grantId, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single word from requester 0.
        sendWord(0, 4'b1011);
        idle(W + 4);
        checkOutput("t1_word", wordsOut.size() >= 1 ? wordsOut[0] : 4'hx, 4'b1011);
        checkOutput("t1_grant", grantsOut.size() >= 1 ? grantsOut[0] : 1'bx, 1'b0);
        checkOutput("t1_ready0_pulses", readyCnt0, 1);
        checkOutput("t1_done_pulses", doneCnt, 1);

        // Requester 1 alone.
        sendWord(1, 4'h6);
        idle(W + 4);
        checkOutput("t2_word", wordsOut.size() >= 2 ? wordsOut[1] : 4'hx, 4'h6);
        checkOutput("t2_grant", grantsOut.size() >= 2 ? grantsOut[1] : 1'bx, 1'b1);
        checkOutput("t2_ready0_pulses", readyCnt0, 1);

        // Both requesters hold valid for four words.
        nA = acceptTimes.size();
        applyStimulus(0, 1'b1, 4'hA);
        applyStimulus(1, 1'b1, 4'h5);
        for (int k = 0; k < 4; k++) waitReady(2);
        applyStimulus(0, 1'b0, 4'hA);
        applyStimulus(1, 1'b0, 4'h5);
        idle(W + 4);
        for (int k = 1; k < 4; k++)
            checkOutput("t3_spacing", (acceptTimes.size() >= nA + 4) ?
                        acceptTimes[nA+k] - acceptTimes[nA+k-1] : -1, 7);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            checkOutput("t3_grant", grantsOut.size() >= 6 ? grantsOut[2+k] : 1'bx, k[0]);
            checkOutput("t3_word", wordsOut.size() >= 6 ? wordsOut[2+k] : 4'hx, k[0] ? 4'h5 : 4'hA);
`else
            checkOutput("t3_grant", grantsOut.size() >= 6 ? grantsOut[2+k] : 1'bx, 1'b0);
            checkOutput("t3_word", wordsOut.size() >= 6 ? wordsOut[2+k] : 4'hx, 4'hA);
`endif
        end
`ifdef ARB_RR_EN
        checkOutput("t3_ready1_pulses", readyCnt1, 3);
`else
        checkOutput("t3_ready1_pulses", readyCnt1, 1);
`endif

        // Request raised while the previous word is shifting.
        nA = acceptTimes.size();
        sendWord(1, 4'h3);
        idle(2);
        sendWord(0, 4'hC);
        idle(W + 4);
        checkOutput("t4_spacing", (acceptTimes.size() >= nA + 2) ?
                    acceptTimes[nA+1] - acceptTimes[nA] : -1, 7);
        checkOutput("t4_word_a", wordsOut.size() >= 8 ? wordsOut[6] : 4'hx, 4'h3);
        checkOutput("t4_word_b", wordsOut.size() >= 8 ? wordsOut[7] : 4'hx, 4'hC);

        // Reset on the second SHIFT cycle abandons the word.
        nW = wordsOut.size();
        nD = doneCnt;
        sendWord(0, 4'hF);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_ser_valid", serValid, 1'b0);
        checkOutput("t5_done", done, 1'b0);
        checkOutput("t5_sr_data", srData, 4'h0);
        idle(W + 2);
        checkOutput("t5_no_done", doneCnt, nD);
        checkOutput("t5_no_word", wordsOut.size(), nW);
        sendWord(1, 4'h9);
        idle(W + 4);
        checkOutput("t5_word", wordsOut.size() >= 9 ? wordsOut[8] : 4'hx, 4'h9);
        checkOutput("t5_grant", grantsOut.size() >= 9 ? grantsOut[8] : 1'bx, 1'b1);

        // One ready pulse per requested word overall.
        checkOutput("ready_pulses_total", readyCnt0 + readyCnt1, 10);
        checkOutput("words_total", wordsOut.size(), 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
